mem_bus_arb: RTL

- Arbitrates the core's single-ported memory bus between instruction fetch (IF) and the load/store path. The load/store path is driven by the decoder's MEM_RW and BYTE_SEL controls.
- Owns the bus FSM: latching requests, byte-lane alignment, wait states, response return, error/timeout reporting.
- Sits between the IF/EX-MEM stages and the external memory/bus.

---
 rtl/mem_bus_arb_pkg.sv | 33 +++
 rtl/mem_bus_arb_lane_align.sv | 23 ++
 rtl/mem_bus_arb.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arb_pkg.sv
// Shared encodings for the memory bus arbiter: FSM states, owners, MEM_RW and BYTE_SEL codes.
// Default STARVE_MAX / TIMEOUT live here so the top and the bench agree.
package mem_bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACC_IF = 2'd1,
        ARB_ACC_LS = 2'd2,
        ARB_RSP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_RD   = 2'b01;
    localparam logic [1:0] MEM_WR   = 2'b10;
    localparam logic [1:0] MEM_ILL  = 2'b11;

    localparam logic [3:0] SEL_B = 4'b0001;
    localparam logic [3:0] SEL_H = 4'b0011;
    localparam logic [3:0] SEL_W = 4'b1111;

    localparam int DEF_STARVE_MAX = 4;
    localparam int DEF_TIMEOUT    = 15;

    function automatic logic sel_legal(input logic [3:0] sel);
        return (sel == SEL_B) || (sel == SEL_H) || (sel == SEL_W);
    endfunction

endpackage

// File: rtl/mem_bus_arb_lane_align.sv
// Byte-lane alignment for a 32-bit bus: byte enables, write-data shift, read-data shift
// and a flag for enables that would spill past lane 3.
module bus_lane_align #(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        i_off,
    input  logic [3:0]        i_sel,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [3:0]        o_be,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_misalign
);
    logic [7:0] w_be_ext;

    assign w_be_ext   = {4'b0000, i_sel} << i_off;
    assign o_be       = w_be_ext[3:0];
    assign o_misalign = |w_be_ext[7:4];
    assign o_wdata    = i_wdata << {i_off, 3'b000};
    assign o_rdata    = i_rdata >> {i_off, 3'b000};

endmodule

// File: rtl/mem_bus_arb.sv
// Single-port memory bus arbiter between instruction fetch and load/store.
// Optional BUS_TIMEOUT_EN: abort an unacknowledged bus cycle after TIMEOUT cycles.
module mem_bus_arb
    import mem_bus_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_err_o,
    input  logic [1:0]        ls_rw_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    input  logic [3:0]        ls_byte_sel_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              ls_err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic [3:0]        bus_be_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_e        r_state, w_next;
    owner_e            r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_sel;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic              r_we, r_bad, r_first, r_rsp_err;
    logic [SW-1:0]     r_starve;

    logic              w_ls_req, w_if_win, w_pick_ls, w_pick_if;
    logic              w_in_acc, w_err, w_expire, w_done;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata_sh, w_rdata_sh;
    logic              w_misalign;

    assign w_ls_req  = (ls_rw_i != MEM_NONE);
    assign w_if_win  = if_req_i && (r_starve == SW'(STARVE_MAX));
    assign w_pick_ls = w_ls_req && !w_if_win;
    assign w_pick_if = if_req_i && !w_pick_ls;
    assign w_in_acc  = (r_state == ARB_ACC_IF) || (r_state == ARB_ACC_LS);
    // IF is latched as a word read, so a non-word-aligned fetch shows up as misalign.
    assign w_err     = w_misalign || r_bad;

    bus_lane_align #(.DATA_W(DATA_W)) u_align (
        .i_off      (r_addr[1:0]),
        .i_sel      (r_sel),
        .i_wdata    (r_wdata),
        .i_rdata    (bus_rdata_i),
        .o_be       (w_be),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_rdata_sh),
        .o_misalign (w_misalign)
    );

`ifdef BUS_TIMEOUT_EN
    logic [TW-1:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (rst || !w_in_acc)  r_to_cnt <= '0;
        else if (!bus_ack_i)   r_to_cnt <= r_to_cnt + 1'b1;
    end

    // A same-cycle ack takes priority over expiry.
    assign w_expire = w_in_acc && !w_err && !bus_ack_i && (r_to_cnt == TW'(TIMEOUT - 1));
`else
    logic [TW-1:0] w_unused_timeout;
    assign w_unused_timeout = TW'(TIMEOUT);
    assign w_expire         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= ARB_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_done      = 1'b0;
        bus_req_o   = 1'b0;
        if_gnt_o    = 1'b0;
        ls_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        ls_rvalid_o = 1'b0;
        if_err_o    = 1'b0;
        ls_err_o    = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_ls)      w_next = ARB_ACC_LS;
                else if (w_pick_if) w_next = ARB_ACC_IF;
            end
            ARB_ACC_IF, ARB_ACC_LS: begin
                bus_req_o = !w_err;
                if_gnt_o  = r_first && (r_state == ARB_ACC_IF);
                ls_gnt_o  = r_first && (r_state == ARB_ACC_LS);
                w_done    = w_err || bus_ack_i || w_expire;
                if (w_done) w_next = ARB_RSP;
            end
            ARB_RSP: begin
                w_next      = ARB_IDLE;
                if_rvalid_o = (r_owner == OWN_IF);
                ls_rvalid_o = (r_owner == OWN_LS);
                if_err_o    = if_rvalid_o && r_rsp_err;
                ls_err_o    = ls_rvalid_o && r_rsp_err;
            end
            default: w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner   <= OWN_IF;
            r_addr    <= '0;
            r_sel     <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_we      <= 1'b0;
            r_bad     <= 1'b0;
            r_first   <= 1'b0;
            r_rsp_err <= 1'b0;
            r_starve  <= '0;
        end else begin
            r_first <= 1'b0;
            if (r_state == ARB_IDLE) begin
                r_starve <= (if_req_i && w_pick_ls) ? r_starve + 1'b1 : '0;
                if (w_pick_ls) begin
                    r_first <= 1'b1;
                    r_owner <= OWN_LS;
                    r_addr  <= ls_addr_i;
                    r_sel   <= ls_byte_sel_i;
                    r_wdata <= ls_wdata_i;
                    r_we    <= (ls_rw_i == MEM_WR);
                    r_bad   <= (ls_rw_i == MEM_ILL) || !sel_legal(ls_byte_sel_i);
                end else if (w_pick_if) begin
                    r_first <= 1'b1;
                    r_owner <= OWN_IF;
                    r_addr  <= if_addr_i;
                    r_sel   <= SEL_W;
                    r_wdata <= '0;
                    r_we    <= 1'b0;
                    r_bad   <= 1'b0;
                end
            end
            if (w_in_acc && w_done) begin
                r_rsp_err <= w_err || !bus_ack_i;
                r_rdata   <= (!w_err && bus_ack_i && !r_we) ? w_rdata_sh : '0;
            end
        end
    end

    assign bus_we_o    = bus_req_o && r_we;
    assign bus_addr_o  = bus_req_o ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign bus_be_o    = bus_req_o ? w_be : 4'b0000;
    assign bus_wdata_o = bus_we_o ? w_wdata_sh : '0;
    assign if_rdata_o  = if_rvalid_o ? r_rdata : '0;
    assign ls_rdata_o  = ls_rvalid_o ? r_rdata : '0;

endmodule
